// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one 16-bit ripple adder between NUM_REQ requesters.
// Optional build macro ADDER_SAT_EN: signed saturating sum plus the res_ovf output.

module adder_16bit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] sum
);
   localparam int unsigned DATA_W = 16;

   // Bit-serial ripple chain; the final carry is dropped (modulo 2^16).
   always_comb begin : ripple
      logic carry;
      carry = 1'b0;
      sum   = '0;
      for (int unsigned i = 0; i < DATA_W; i++) begin
         sum[i] = a[i] ^ b[i] ^ carry;
         carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
   end
endmodule

module adder_rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [16*NUM_REQ-1:0]   req_a,
   input  logic [16*NUM_REQ-1:0]   req_b,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [15:0]             res_sum,
`ifdef ADDER_SAT_EN
   output logic                    res_ovf,
`endif
   output logic [ID_W-1:0]         res_id
);
   localparam int unsigned DATA_W = 16;

   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   grant_id;
   logic [ID_W-1:0]   scan_idx;
   logic              grant_found;
   logic              can_accept;
   logic              handshake;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic [DATA_W-1:0] raw_sum;
   logic [DATA_W-1:0] next_sum;

   // First valid requester at or after rr_ptr, wrapping.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      scan_idx    = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         scan_idx = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
         if (!grant_found && req_valid[scan_idx]) begin
            grant_found = 1'b1;
            grant_id    = scan_idx;
         end
      end
   end

   assign can_accept = !res_valid || res_ready;
   assign handshake  = grant_found && can_accept && !rst;

   always_comb begin
      req_ready = '0;
      if (handshake) req_ready[grant_id] = 1'b1;
   end

   assign op_a = req_a[{grant_id, 4'h0} +: DATA_W];
   assign op_b = req_b[{grant_id, 4'h0} +: DATA_W];

   adder_16bit u_adder (
      .a   (op_a),
      .b   (op_b),
      .sum (raw_sum)
   );

`ifdef ADDER_SAT_EN
   logic next_ovf;

   // Same-sign operands producing an opposite-sign result overflowed.
   assign next_ovf = (op_a[15] == op_b[15]) && (raw_sum[15] != op_a[15]);
   assign next_sum = next_ovf ? (op_a[15] ? 16'h8000 : 16'h7FFF) : raw_sum;
`else
   assign next_sum = raw_sum;
`endif

   // Single-entry result stage; a drain and a new load may coincide.
   always_ff @(posedge clk) begin
      if (rst) begin
         res_valid <= 1'b0;
         res_sum   <= '0;
         res_id    <= '0;
         rr_ptr    <= '0;
`ifdef ADDER_SAT_EN
         res_ovf   <= 1'b0;
`endif
      end else if (handshake) begin
         res_valid <= 1'b1;
         res_sum   <= next_sum;
         res_id    <= grant_id;
         rr_ptr    <= ID_W'((32'(grant_id) + 1) % NUM_REQ);
`ifdef ADDER_SAT_EN
         res_ovf   <= next_ovf;
`endif
      end else if (res_ready) begin
         res_valid <= 1'b0;
      end
   end
endmodule
